// File: rtl/adc_sim_mc_if.sv
// Bundle of sampling controls, analogue inputs and quantised results for adc_sim_mc.
// The stimulus side drives through master; the ADC model attaches through slave.
interface adc_sim_mc_if #(
    parameter int CH   = 4,
    parameter int BITS = 8
);
    logic                     en;
    real                      in [CH];
    logic                     ovfl_clr;
    logic [CH-1:0][BITS-1:0]  code;
    logic                     valid;
    logic [CH-1:0]            ovfl_pos;
    logic [CH-1:0]            ovfl_neg;
    logic [CH-1:0]            ovfl_sticky;

    modport master (
        output en, in, ovfl_clr,
        input  code, valid, ovfl_pos, ovfl_neg, ovfl_sticky
    );

    modport slave (
        input  en, in, ovfl_clr,
        output code, valid, ovfl_pos, ovfl_neg, ovfl_sticky
    );
endinterface

// File: rtl/adc_sim_mc.sv
// Behavioural multi-channel ADC: divided-rate sampling, per-channel quantisation,
// fixed-latency result pipeline with aligned overflow flags and sticky overflow.
module adc_sim_mc #(
    parameter int    CH   = 4,
    parameter int    BITS = 8,
    parameter real   VPP  = 1.0,
    parameter int    PIPE = 5,
    parameter int    DIV  = 1,
    parameter string TYPE = "unsigned"
) (
    input logic          clk,
    input logic          rst_n,
    adc_sim_mc_if.slave  bus
);
    localparam int  CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam bit  SIGNED_CODE = (TYPE == "signed");
    localparam real HALF        = VPP / 2.0;
    localparam real FULL        = 2.0 ** BITS;
    localparam int  UMAX_I      = (1 << BITS) - 1;

    typedef struct packed {
        logic                    valid;
        logic [CH-1:0][BITS-1:0] code;
        logic [CH-1:0]           pos;
        logic [CH-1:0]           neg;
    } stage_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe;
    stage_t        pipe_q [PIPE];
    stage_t        pipe_d [PIPE];
    stage_t        out_s;
    logic [CH-1:0] sticky_q, sticky_d;

    logic [CH-1:0][BITS-1:0] qcode;
    logic [CH-1:0]           qpos;
    logic [CH-1:0]           qneg;
    real                     scaled;
    int                      u;

    // Divider: en low parks the counter at 0 so re-enabling samples immediately.
    always_comb begin
        strobe = bus.en && (cnt_q == '0);
        cnt_d  = cnt_q;
        if (!bus.en)
            cnt_d = '0;
        else if (cnt_q == CW'(DIV - 1))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        qcode  = '0;
        qpos   = '0;
        qneg   = '0;
        scaled = 0.0;
        u      = 0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (bus.in[i] >= HALF) begin
                qcode[i] = '1;
                qpos[i]  = 1'b1;
            end else if (bus.in[i] <= -HALF) begin
                qcode[i] = '0;
                qneg[i]  = 1'b1;
            end else begin
                // Inside the open range scaled is non-negative, so truncation is floor.
                scaled = ((bus.in[i] + HALF) / VPP) * FULL;
                u      = $rtoi(scaled);
                if (u > UMAX_I) u = UMAX_I;
                if (u < 0)      u = 0;
                qcode[i] = u[BITS-1:0];
            end
            if (SIGNED_CODE)
                qcode[i][BITS-1] = ~qcode[i][BITS-1];
        end
    end

    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = 1'b0;
        if (strobe)
            pipe_d[0] = '{valid: 1'b1, code: qcode, pos: qpos, neg: qneg};
        for (int unsigned i = 1; i < PIPE; i++)
            pipe_d[i] = pipe_q[i-1];
    end

    assign out_s = pipe_q[PIPE-1];

    // Set beats clear when both happen on the same edge.
    always_comb begin
        sticky_d = bus.ovfl_clr ? '0 : sticky_q;
        if (out_s.valid)
            sticky_d = sticky_d | out_s.pos | out_s.neg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            sticky_q <= '0;
            for (int unsigned i = 0; i < PIPE; i++)
                pipe_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            pipe_q   <= pipe_d;
        end
    end

    assign bus.code        = out_s.code;
    assign bus.valid       = out_s.valid;
    assign bus.ovfl_pos    = out_s.pos;
    assign bus.ovfl_neg    = out_s.neg;
    assign bus.ovfl_sticky = sticky_q;
endmodule

// File: tb/tb_adc_sim_mc.sv
// Directed bench for adc_sim_mc: unsigned/signed coding, overflow, sticky, divider, reset.
module tb_adc_sim_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    adc_sim_mc_if #(.CH(1), .BITS(8)) if0 ();
    adc_sim_mc_if #(.CH(1), .BITS(8)) if1 ();
    adc_sim_mc_if #(.CH(4), .BITS(8)) if2 ();

    adc_sim_mc #(.CH(1), .BITS(8), .VPP(1.0), .PIPE(5), .DIV(1), .TYPE("unsigned"))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    adc_sim_mc #(.CH(1), .BITS(8), .VPP(1.0), .PIPE(5), .DIV(1), .TYPE("signed"))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    adc_sim_mc #(.CH(4), .BITS(8), .VPP(1.0), .PIPE(5), .DIV(4), .TYPE("unsigned"))
        u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    function automatic int ramp_code(input int c, input int t);
        return 16 + 40 * c + 3 * t;
    endfunction

    // One-edge strobe on instance 0 or 1, then watch 8 cycles for the result.
    task automatic sample1(input int which, input real v, output int lat, output int nvalid,
                           output logic [7:0] c, output logic p, output logic n);
        if (which == 0) begin if0.en = 1'b1; if0.in[0] = v; end
        else            begin if1.en = 1'b1; if1.in[0] = v; end
        @(posedge clk);
        @(negedge clk);
        if0.en = 1'b0; if1.en = 1'b0;
        lat = -1; nvalid = 0; c = '0; p = 1'b0; n = 1'b0;
        for (int j = 0; j < 8; j++) begin
            logic       vv;
            logic [7:0] cc;
            logic       pp, nn;
            if (j > 0) @(negedge clk);
            vv = (which == 0) ? if0.valid       : if1.valid;
            cc = (which == 0) ? if0.code[0]     : if1.code[0];
            pp = (which == 0) ? if0.ovfl_pos[0] : if1.ovfl_pos[0];
            nn = (which == 0) ? if0.ovfl_neg[0] : if1.ovfl_neg[0];
            if (vv) begin
                nvalid++;
                if (lat < 0) begin lat = j; c = cc; p = pp; n = nn; end
            end
        end
    endtask

    task automatic test_reset();
        if0.en = 0; if1.en = 0; if2.en = 0;
        if0.ovfl_clr = 0; if1.ovfl_clr = 0; if2.ovfl_clr = 0;
        if0.in[0] = 0.0; if1.in[0] = 0.0;
        for (int c = 0; c < 4; c++) if2.in[c] = 0.0;
        #12;
        checks++; if (if0.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", if0.valid); else passed++;
        checks++; if (if0.code !== 8'h00) $display("FAIL reset_code got=%h exp=00", if0.code); else passed++;
        checks++; if (if2.code !== 32'h0) $display("FAIL reset_code4 got=%h exp=0", if2.code); else passed++;
        checks++; if ({if0.ovfl_pos, if0.ovfl_neg, if0.ovfl_sticky} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {if0.ovfl_pos, if0.ovfl_neg, if0.ovfl_sticky}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vectors(input int which, input string tag, input real vin [3],
                               input logic [7:0] ecode [3], input logic [1:0] eflag [3]);
        int lat, nv; logic [7:0] c; logic p, n;
        for (int k = 0; k < 3; k++) begin
            sample1(which, vin[k], lat, nv, c, p, n);
            checks++; if (lat !== 4 || nv !== 1)
                $display("FAIL %s_latency[%0d] got lat=%0d n=%0d exp lat=4 n=1", tag, k, lat, nv); else passed++;
            checks++; if (c !== ecode[k])
                $display("FAIL %s_code[%0d] got=%h exp=%h", tag, k, c, ecode[k]); else passed++;
            checks++; if ({p, n} !== eflag[k])
                $display("FAIL %s_flags[%0d] got=%b exp=%b", tag, k, {p, n}, eflag[k]); else passed++;
        end
    endtask

    task automatic test_unsigned();
        run_vectors(0, "uns", '{0.0, 0.25, -0.25}, '{8'd128, 8'd192, 8'd64}, '{2'b00, 2'b00, 2'b00});
        checks++; if (if0.ovfl_sticky !== 1'b0)
            $display("FAIL uns_sticky got=%b exp=0", if0.ovfl_sticky); else passed++;
    endtask

    task automatic test_overflow();
        run_vectors(0, "ovf", '{0.5, 0.7, -0.5}, '{8'd255, 8'd255, 8'd0}, '{2'b10, 2'b10, 2'b01});
        checks++; if (if0.ovfl_sticky !== 1'b1)
            $display("FAIL ovf_sticky got=%b exp=1", if0.ovfl_sticky); else passed++;
    endtask

    task automatic test_signed();
        run_vectors(1, "sgn", '{0.0, 0.4999, -0.5}, '{8'h00, 8'h7F, 8'h80}, '{2'b00, 2'b00, 2'b01});
    endtask

    task automatic test_sticky();
        int lat, nv; logic [7:0] c; logic p, n; bit seen;
        if0.ovfl_clr = 1'b1; @(posedge clk); @(negedge clk); if0.ovfl_clr = 1'b0;
        checks++; if (if0.ovfl_sticky !== 1'b0)
            $display("FAIL sticky_clear0 got=%b exp=0", if0.ovfl_sticky); else passed++;
        sample1(0, 0.7, lat, nv, c, p, n);
        checks++; if (if0.ovfl_sticky !== 1'b1)
            $display("FAIL sticky_set got=%b exp=1", if0.ovfl_sticky); else passed++;
        if0.en = 1'b1; if0.in[0] = 0.6;
        @(posedge clk); @(negedge clk); if0.en = 1'b0;
        seen = 0;
        for (int j = 0; j < 8 && !seen; j++) begin
            if (if0.valid) seen = 1;
            else @(negedge clk);
        end
        checks++; if (!seen) $display("FAIL sticky_wait got=no_valid exp=valid"); else passed++;
        if0.ovfl_clr = 1'b1; @(posedge clk); @(negedge clk); if0.ovfl_clr = 1'b0;
        checks++; if (if0.ovfl_sticky !== 1'b1)
            $display("FAIL sticky_set_wins got=%b exp=1", if0.ovfl_sticky); else passed++;
        if0.ovfl_clr = 1'b1; @(posedge clk); @(negedge clk); if0.ovfl_clr = 1'b0;
        checks++; if (if0.ovfl_sticky !== 1'b0)
            $display("FAIL sticky_clear1 got=%b exp=0", if0.ovfl_sticky); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_c [3] = '{8'd128, 8'd192, 8'd64};
        real        vin [3]   = '{0.0, 0.25, -0.25};
        logic       ev;
        for (int k = 0; k < 3; k++) begin
            if0.en = 1'b1; if0.in[0] = vin[k];
            @(posedge clk); @(negedge clk);
        end
        if0.en = 1'b0;
        for (int j = 2; j < 10; j++) begin
            if (j > 2) @(negedge clk);
            ev = (j >= 4 && j <= 6);
            checks++; if (if0.valid !== ev)
                $display("FAIL b2b_valid[%0d] got=%b exp=%b", j, if0.valid, ev); else passed++;
            if (ev) begin
                checks++; if (if0.code[0] !== exp_c[j-4])
                    $display("FAIL b2b_code[%0d] got=%0d exp=%0d", j, if0.code[0], exp_c[j-4]); else passed++;
            end
        end
    endtask

    task automatic test_div4();
        logic ev;
        for (int t = 0; t < 24; t++) begin
            if2.en = 1'b1;
            for (int c = 0; c < 4; c++)
                if2.in[c] = real'(ramp_code(c, t) - 128) / 256.0 + 0.001;
            @(posedge clk); @(negedge clk);
            ev = (t >= 4) && (t % 4 == 0);
            checks++; if (if2.valid !== ev)
                $display("FAIL div4_valid[%0d] got=%b exp=%b", t, if2.valid, ev); else passed++;
            if (ev) begin
                for (int c = 0; c < 4; c++) begin
                    checks++; if (if2.code[c] !== 8'(ramp_code(c, t - 4)))
                        $display("FAIL div4_code[t%0d,c%0d] got=%0d exp=%0d", t, c, if2.code[c], ramp_code(c, t - 4));
                    else passed++;
                end
            end
        end
        if2.en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); @(negedge clk);
            ev = (j == 0);
            checks++; if (if2.valid !== ev)
                $display("FAIL div4_drain[%0d] got=%b exp=%b", j, if2.valid, ev); else passed++;
            if (j == 0 || j == 9) begin
                for (int c = 0; c < 4; c++) begin
                    checks++; if (if2.code[c] !== 8'(ramp_code(c, 20)))
                        $display("FAIL div4_hold[j%0d,c%0d] got=%0d exp=%0d", j, c, if2.code[c], ramp_code(c, 20));
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat, nv; logic [7:0] c; logic p, n;
        for (int k = 0; k < 3; k++) begin
            if0.en = 1'b1; if0.in[0] = 0.25;
            @(posedge clk); @(negedge clk);
        end
        if0.en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if0.code !== 8'h00 || if0.valid !== 1'b0)
            $display("FAIL midrst_async got code=%h valid=%b exp code=00 valid=0", if0.code, if0.valid); else passed++;
        checks++; if (if2.code !== 32'h0)
            $display("FAIL midrst_code4 got=%h exp=0", if2.code); else passed++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        sample1(0, 0.0, lat, nv, c, p, n);
        checks++; if (lat !== 4 || nv !== 1)
            $display("FAIL midrst_latency got lat=%0d n=%0d exp lat=4 n=1", lat, nv); else passed++;
        checks++; if (c !== 8'd128)
            $display("FAIL midrst_code got=%0d exp=128", c); else passed++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_overflow();
        test_signed();
        test_sticky();
        test_back_to_back();
        test_div4();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
